// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-port load/store unit; optional LSU_SIGNEXT_EN sign-extends byte loads
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        mem_w,
    output logic        mem_r,
    output logic        mem_sb,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wd,
    input  logic [15:0] mem_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        range_err;
    logic [15:0] load_data;

    // A word access at the last address would straddle the top of memory.
    assign range_err = !req_byte && (req_addr == 16'hFFFF);
    assign accept    = req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them at once.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !range_err) begin
                    state_next = req_we ? WR : RD;
                end
            end
            WR: begin
                mem_w      = 1'b1;
                state_next = IDLE;
            end
            RD: begin
                mem_r      = 1'b1;
                state_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_data = mem_rd;
        if (mem_sb) begin
`ifdef LSU_SIGNEXT_EN
            load_data = {{8{mem_rd[7]}}, mem_rd[7:0]};
`else
            load_data = {8'h00, mem_rd[7:0]};
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= 16'h0000;
            mem_wd   <= 16'h0000;
            mem_sb   <= 1'b0;
            fault    <= 1'b0;
            rsp_data <= 16'h0000;
        end else begin
            if (accept) begin
                mem_addr <= req_addr;
                mem_wd   <= req_wdata;
                mem_sb   <= req_byte;
                fault    <= range_err;
            end
            if (state == RD) begin
                rsp_data <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        mem_w;
    logic        mem_r;
    logic        mem_sb;
    logic [15:0] mem_addr;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_w     (mem_w),
        .mem_r     (mem_r),
        .mem_sb    (mem_sb),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .fault     (fault)
    );

    task automatic drive_req(input logic we, input logic bt, input logic [15:0] addr,
                             input logic [15:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; mem_rd = 16'h0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, mem_w, mem_r, mem_sb, rsp_valid, fault} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000", {req_ready, mem_w, mem_r, mem_sb, rsp_valid, fault});
        end
        checks++;
        if ({mem_addr, mem_wd, rsp_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wd, rsp_data});
        end
        reset = 1'b0;
    endtask

    task automatic test_word_store;
        @(negedge clk);
        drive_req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({mem_w, mem_r, mem_sb, req_ready, mem_addr, mem_wd} !== {4'b1000, 16'h0010, 16'hBEEF}) begin
            errors++;
            $display("FAIL store_wr: got w%b r%b sb%b rdy%b a%h d%h want w1 r0 sb0 rdy0 a0010 dBEEF",
                     mem_w, mem_r, mem_sb, req_ready, mem_addr, mem_wd);
        end
        @(negedge clk);
        checks++;
        if ({mem_w, req_ready, mem_addr, mem_wd} !== {2'b01, 16'h0010, 16'hBEEF}) begin
            errors++;
            $display("FAIL store_done: got w%b rdy%b a%h d%h want w0 rdy1 a0010 dBEEF",
                     mem_w, req_ready, mem_addr, mem_wd);
        end
    endtask

    task automatic do_load(input string name, input logic bt, input logic [15:0] addr,
                           input logic [15:0] rd, input logic [15:0] exp);
        @(negedge clk);
        rsp_ready = 1'b1;
        mem_rd = rd;
        drive_req(1'b0, bt, addr, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({mem_r, mem_w, rsp_valid, mem_sb, mem_addr} !== {3'b100, bt, addr}) begin
            errors++;
            $display("FAIL %s_rd: got r%b w%b v%b sb%b a%h want r1 w0 v0 sb%b a%h",
                     name, mem_r, mem_w, rsp_valid, mem_sb, mem_addr, bt, addr);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, mem_r, rsp_data} !== {2'b10, exp}) begin
            errors++;
            $display("FAIL %s_rsp: got v%b r%b data %h want v1 r0 data %h",
                     name, rsp_valid, mem_r, rsp_data, exp);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL %s_end: got v%b rdy%b want v0 rdy1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_word_load;
        do_load("word_load", 1'b0, 16'h0004, 16'h1234, 16'h1234);
    endtask

    task automatic test_byte_load;
`ifdef LSU_SIGNEXT_EN
        do_load("byte_load", 1'b1, 16'h0005, 16'h00AD, 16'hFFAD);
        do_load("byte_load_pos", 1'b1, 16'h0006, 16'h9C3F, 16'h003F);
`else
        do_load("byte_load", 1'b1, 16'h0005, 16'h00AD, 16'h00AD);
        do_load("byte_load_hi", 1'b1, 16'h0006, 16'h9CF3, 16'h00F3);
`endif
    endtask

    task automatic test_rsp_stall;
        @(negedge clk);
        rsp_ready = 1'b0;
        mem_rd = 16'h5A5A;
        drive_req(1'b0, 1'b0, 16'h0008, 16'h0);
        @(negedge clk);
        @(negedge clk);
        mem_rd = 16'h0000;
        drive_req(1'b1, 1'b0, 16'h0030, 16'h7777);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, req_ready, mem_w, rsp_data, mem_addr} !== {3'b100, 16'h5A5A, 16'h0008}) begin
                errors++;
                $display("FAIL stall_%0d: got v%b rdy%b w%b data %h a%h want v1 rdy0 w0 data 5A5A a0008",
                         i, rsp_valid, req_ready, mem_w, rsp_data, mem_addr);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready, mem_w, mem_addr} !== {3'b010, 16'h0008}) begin
            errors++;
            $display("FAIL stall_release: got v%b rdy%b w%b a%h want v0 rdy1 w0 a0008",
                     rsp_valid, req_ready, mem_w, mem_addr);
        end
    endtask

    task automatic test_fault;
        @(negedge clk);
        drive_req(1'b1, 1'b0, 16'hFFFF, 16'h4444);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({fault, mem_w, mem_r, req_ready, rsp_valid} !== 5'b10010) begin
            errors++;
            $display("FAIL fault_store: got f%b w%b r%b rdy%b v%b want f1 w0 r0 rdy1 v0",
                     fault, mem_w, mem_r, req_ready, rsp_valid);
        end
        drive_req(1'b0, 1'b0, 16'hFFFF, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({fault, mem_w, mem_r, req_ready, rsp_valid} !== 5'b10010) begin
            errors++;
            $display("FAIL fault_load: got f%b w%b r%b rdy%b v%b want f1 w0 r0 rdy1 v0",
                     fault, mem_w, mem_r, req_ready, rsp_valid);
        end
        mem_rd = 16'h1277;
        drive_req(1'b0, 1'b1, 16'hFFFF, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({fault, mem_r, mem_sb, mem_addr} !== {3'b011, 16'hFFFF}) begin
            errors++;
            $display("FAIL fault_byte_rd: got f%b r%b sb%b a%h want f0 r1 sb1 aFFFF",
                     fault, mem_r, mem_sb, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 16'h0077}) begin
            errors++;
            $display("FAIL fault_byte_rsp: got v%b data %h want v1 data 0077", rsp_valid, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rsp_ready = 1'b0;
        mem_rd = 16'hCAFE;
        drive_req(1'b0, 1'b0, 16'h0040, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_r, mem_w, rsp_valid, req_ready, fault, mem_sb, mem_addr, mem_wd, rsp_data} !== {6'b000100, 48'h0}) begin
            errors++;
            $display("FAIL reset_in_rd: got r%b w%b v%b rdy%b f%b sb%b a%h d%h rsp%h want idle and zeros",
                     mem_r, mem_w, rsp_valid, req_ready, fault, mem_sb, mem_addr, mem_wd, rsp_data);
        end
        @(negedge clk);
        reset = 1'b0;
        drive_req(1'b0, 1'b0, 16'h0042, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 16'hCAFE}) begin
            errors++;
            $display("FAIL load_before_rst_rsp: got v%b data %h want v1 CAFE", rsp_valid, rsp_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req_ready, mem_r, rsp_data, mem_addr} !== {3'b010, 32'h0}) begin
            errors++;
            $display("FAIL reset_in_rsp: got v%b rdy%b r%b data %h a%h want v0 rdy1 r0 data 0000 a0000",
                     rsp_valid, req_ready, mem_r, rsp_data, mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        do_load("post_reset_load", 1'b0, 16'h0044, 16'h8001, 16'h8001);
    endtask

    task automatic test_back_to_back;
        int pulses;
        logic [15:0] addrs [3];
        logic [15:0] rds [3];
        addrs[0] = 16'h0100; addrs[1] = 16'h0102; addrs[2] = 16'h0104;
        rds[0] = 16'h1111; rds[1] = 16'h2222; rds[2] = 16'h3333;
        pulses = 0;
        @(negedge clk);
        drive_req(1'b1, 1'b0, addrs[0], 16'hA000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pulses += int'(mem_w);
            checks++;
            if ({mem_w, mem_addr, mem_wd} !== {1'b1, addrs[i], 16'hA000 + 16'(i)}) begin
                errors++;
                $display("FAIL b2b_store_%0d: got w%b a%h d%h want w1 a%h d%h",
                         i, mem_w, mem_addr, mem_wd, addrs[i], 16'hA000 + 16'(i));
            end
            if (i < 2) drive_req(1'b1, 1'b0, addrs[i+1], 16'hA000 + 16'(i + 1));
            else req_valid = 1'b0;
            @(negedge clk);
            pulses += int'(mem_w);
        end
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL b2b_store_pulses: got %0d want 3", pulses);
        end
        rsp_ready = 1'b1;
        mem_rd = rds[0];
        drive_req(1'b0, 1'b0, addrs[0], 16'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mem_r, mem_addr} !== {1'b1, addrs[i]}) begin
                errors++;
                $display("FAIL b2b_load_rd_%0d: got r%b a%h want r1 a%h", i, mem_r, mem_addr, addrs[i]);
            end
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_data} !== {1'b1, rds[i]}) begin
                errors++;
                $display("FAIL b2b_load_rsp_%0d: got v%b data %h want v1 data %h", i, rsp_valid, rsp_data, rds[i]);
            end
            if (i < 2) begin
                mem_rd = rds[i+1];
                drive_req(1'b0, 1'b0, addrs[i+1], 16'h0);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL b2b_load_idle_%0d: got v%b rdy%b want v0 rdy1", i, rsp_valid, req_ready);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mem_w && mem_r) begin
            errors++;
            $display("FAIL strobe_exclusive: got w%b r%b want not both", mem_w, mem_r);
        end
    end

    initial begin
        test_reset;
        test_word_store;
        test_word_load;
        test_byte_load;
        test_rsp_stall;
        test_fault;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these ports (clock and reset first), one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents a memory request.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = 16-bit word access.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; byte stores use [7:0].
- mem_w  out  1  write strobe to data memory.
- mem_r  out  1  read enable to data memory.
- mem_sb  out  1  byte-access select to data memory.
- mem_addr  out  16  data-memory address.
- mem_wd  out  16  data-memory write data.
- mem_rd  in  16  data-memory read data, combinational from mem_addr, {upper byte at addr+1, lower byte at addr}.
- rsp_valid  out  1  load result available.
- rsp_ready  in  1  consumer takes the load result.
- rsp_data  out  16  load result.
- fault  out  1  last accepted request was rejected as out of range.
REQ-002 The block SHALL have no parameters; its one option is the macro in REQ-015.

Function
REQ-003 The block SHALL run a registered FSM with states IDLE, WR, RD and RSP.
REQ-004 The block SHALL drive req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-005 On accept, the block SHALL register addr, wdata, byte and we into mem_addr, mem_wd and mem_sb, and SHALL clear fault.
REQ-006 A word request with req_addr = 16'hFFFF SHALL NOT be performed: fault <= 1, state stays IDLE, no strobe, no rsp_valid.
REQ-007 An accepted store SHALL go IDLE->WR; in WR, mem_w = 1 for exactly one cycle, then WR->IDLE; stores produce no response.
REQ-008 An accepted load SHALL go IDLE->RD; in RD, mem_r = 1 for exactly one cycle; on the RD->RSP edge, mem_rd is captured into rsp_data.
REQ-009 For a word load, rsp_data SHALL equal mem_rd; for a byte load, rsp_data SHALL equal {8'h00, mem_rd[7:0]}, except as set by REQ-015.
REQ-010 In RSP, rsp_valid SHALL be 1 and rsp_data stable until rsp_ready = 1; on that edge the FSM SHALL go RSP->IDLE and rsp_valid SHALL drop.
REQ-011 Latencies SHALL be fixed:
- Store: accept to end of mem_w, 2 edges.
- Load: accept to rsp_valid high, 2 edges.
- Minimum back-to-back: store every 2 cycles; load every 3 cycles (when rsp_ready is held at 1).
REQ-012 mem_w and mem_r SHALL never both be 1, and SHALL both be 0 in IDLE and RSP.
REQ-013 mem_addr, mem_wd and mem_sb SHALL hold their last values outside WR and RD.

Reset
REQ-014 While reset = 1 (asynchronous), the block SHALL hold:
- state IDLE, so req_ready = 1.
- mem_w, mem_r, mem_sb, rsp_valid and fault = 0.
- mem_addr, mem_wd and rsp_data = 16'h0000.
- Reset in WR or RD SHALL abort the access immediately, with no partial strobe after reset asserts.
- Reset in RSP SHALL discard the pending result.

Configuration
REQ-015 Macro LSU_SIGNEXT_EN SHALL select the byte-load result:
- Defined: byte loads return {{8{mem_rd[7]}}, mem_rd[7:0]}.
- Undefined: byte loads are zero-extended per REQ-009.
- Word loads are unaffected either way.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Word store addr 16'h0010, data 16'hBEEF -> exactly one cycle of mem_w=1, mem_sb=0, mem_addr=16'h0010, mem_wd=16'hBEEF; req_ready back to 1 after 2 edges.
- Word load addr 16'h0004, mem_rd model returns 16'h1234, rsp_ready=1 -> rsp_valid for 1 cycle with rsp_data=16'h1234, 2 edges after accept.
- Byte load, mem_rd=16'h00AD -> rsp_data=16'h00AD; with LSU_SIGNEXT_EN defined, rsp_data=16'hFFAD.
- Load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; new req_valid is ignored until the handshake completes.
- Word request at 16'hFFFF -> fault=1, no mem_w or mem_r, req_ready stays 1; next valid request clears fault; a byte request at 16'hFFFF is performed normally.
- reset pulsed during RD and during RSP -> strobes and rsp_valid drop immediately, all outputs at REQ-014 values, and the next request behaves normally.
